serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/serial_subtractor_full_sub.sv | 16 +
 rtl/serial_subtractor.sv | 156 +++++++++++++++
 tb/tb_serial_subtractor.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and helpers for the bit-serial subtractor.
//   sub_state_t : FSM state encoding (IDLE, SHIFT, DONE)
//   CNT_W()     : bit-counter width for a given operand width
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    // Width of a counter that indexes bit positions 0 .. width-1.
    function automatic int CNT_W(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// full_sub: combinational 1-bit full subtractor, computes a - b - bin.
//   a, b, bin : minuend bit, subtrahend bit, borrow-in
//   d, bo     : difference bit, borrow-out
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when they are equal and a borrow arrives.
    assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Bin, LSB first, one bit per clock.
// Result uses the adder's packed format {borrow_out, diff}.
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   start         : request, sampled only when not busy
//   a, b, bin     : operands, captured on an accepted start
//   busy          : high while bits are being processed (WIDTH cycles)
//   done          : one-cycle pulse when result is updated
//   result        : {borrow_out, diff}, holds last completed value
//   ovf           : signed overflow of the last operation
//                   (only when SERIAL_SUB_OVF_EN is defined)
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int             CW       = CNT_W(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   result_q, result_d;
    logic             d_bit, bo_bit;
    logic             last_bit;

    full_sub u_full_sub (
        .a   (a_sr_q[0]),
        .b   (b_sr_q[0]),
        .bin (br_q),
        .d   (d_bit),
        .bo  (bo_bit)
    );

    assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        diff_sr_d = diff_sr_q;
        br_d      = br_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d    = a;
                    b_sr_d    = b;
                    br_d      = bin;
                    cnt_d     = '0;
                    diff_sr_d = '0;
                    state_d   = SHIFT;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                diff_sr_d = {d_bit, diff_sr_q[WIDTH-1:1]};
                a_sr_d    = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d    = {1'b0, b_sr_q[WIDTH-1:1]};
                br_d      = bo_bit;
                cnt_d     = cnt_q + CW'(1);
                if (last_bit) begin
                    // Final bit goes straight into the result; diff_sr_q[0]
                    // is the stale slot that would be shifted out.
                    result_d = {bo_bit, d_bit, diff_sr_q[WIDTH-1:1]};
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            diff_sr_q <= '0;
            br_q      <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            diff_sr_q <= diff_sr_d;
            br_q      <= br_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    // The LSB of the difference register never reaches the result.
    logic unused_diff_lsb;
    assign unused_diff_lsb = diff_sr_q[0];

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign result = result_q;

`ifdef SERIAL_SUB_OVF_EN
    // Operand MSBs are gone from the shift registers by the last bit, so
    // keep private copies taken at acceptance.
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;

    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        if ((state_q != SHIFT) && start) begin
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
        end
        if (last_bit) begin
            // Signs differ and the result sign disagrees with the minuend.
            ovf_d = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH = 4). Optional ovf checks
// are compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   result;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .result (result)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full operation: busy for WIDTH cycles with result held, then done
    // with the expected result, then back to idle.
    task automatic op(input string tag, input logic [3:0] ai, input logic [3:0] bi,
                      input logic bi_n, input logic [4:0] exp, input logic [4:0] prev);
        start = 1'b1; a = ai; b = bi; bin = bi_n;
        step();                      // accepting edge k
        start = 1'b0; a = 4'hx; b = 4'hx; bin = 1'bx;
        for (int i = 0; i < WIDTH; i++) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_nodone"}, done, 0);
            chk({tag, "_hold"}, result, prev);
            step();
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_notbusy"}, busy, 0);
        chk({tag, "_result"}, result, exp);
        step();
        chk({tag, "_donepulse"}, done, 0);
        chk({tag, "_keep"}, result, exp);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);

        op("nobrw",  4'd9, 4'd3, 1'b0, 5'b0_0110, 5'b0_0000);
        op("brw",    4'd3, 4'd9, 1'b0, 5'b1_1010, 5'b0_0110);
        op("binonly",4'd0, 4'd0, 1'b1, 5'b1_1111, 5'b1_1010);

        // Ignored start mid-operation, then back-to-back start held in DONE.
        start = 1'b1; a = 4'd9; b = 4'd3; bin = 1'b0;
        step();                      // k
        start = 1'b0;
        chk("ign_busy1", busy, 1);
        step();                      // cycle k+2
        start = 1'b1; a = 4'd15; b = 4'd15; bin = 1'b0;
        step();
        start = 1'b0;
        chk("ign_busy3", busy, 1);
        chk("ign_hold", result, 5'b1_1111);
        step();
        chk("ign_busy4", busy, 1);
        step();                      // cycle k+5
        chk("ign_done", done, 1);
        chk("ign_result", result, 5'b0_0110);
        start = 1'b1; a = 4'd15; b = 4'd15; bin = 1'b0;
        step();                      // accepted in DONE
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_nodone", done, 0);
        chk("b2b_hold", result, 5'b0_0110);
        step(); step(); step();
        chk("b2b_busy4", busy, 1);
        step();
        chk("b2b_done", done, 1);
        chk("b2b_result", result, 5'b0_0000);
        step();
        chk("b2b_idle", done, 0);

        op("brw2", 4'd3, 4'd9, 1'b0, 5'b1_1010, 5'b0_0000);

        // Reset mid-operation at cycle k+2.
        start = 1'b1; a = 4'd9; b = 4'd3; bin = 1'b0;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_result", result, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("post_rst_nodone", done, 0);
            chk("post_rst_nobusy", busy, 0);
        end
        chk("post_rst_result", result, 0);
        op("recover", 4'd5, 4'd4, 1'b0, 5'b0_0001, 5'b0_0000);

`ifdef SERIAL_SUB_OVF_EN
        op("ovf1", 4'd7, 4'd8, 1'b0, 5'b1_1111, 5'b0_0001);
        chk("ovf_set", ovf, 1);
        op("ovf0", 4'd5, 4'd2, 1'b0, 5'b0_0011, 5'b1_1111);
        chk("ovf_clr", ovf, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
